// File: rtl/pss_pkg.sv
// pss_pkg: shared types and helpers for pattern_scan_scheduler.
//   pss_state_t : scheduler FSM state encoding
//   cnt_w()     : width needed to hold a match count of 0..word_w
//   rr_next()   : round-robin successor of a requester index
package pss_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      REPORT = 2'd2
   } pss_state_t;

   // Width of a counter that must reach word_w inclusive.
   function automatic int unsigned cnt_w(input int unsigned word_w);
      return $clog2(word_w + 1);
   endfunction

   // Next round-robin pointer after granting idx, wrapping at n_req.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n_req);
      return (idx + 1 >= n_req) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/pattern_scan_scheduler_if.sv
// pattern_scan_scheduler_if: request/response bundle of the scan scheduler.
//   req_valid/req_data/req_ready : per-requester word submission (slave accepts)
//   resp_valid/resp_id/resp_count/resp_ready : tagged result channel
//   busy : scheduler is not idle
// Modports: master = producers/consumer side, slave = scheduler side.
interface pattern_scan_scheduler_if #(
   parameter int unsigned N_REQ  = 4,
   parameter int unsigned WORD_W = 16
);
   import pss_pkg::*;

   localparam int unsigned ID_W  = $clog2(N_REQ);
   localparam int unsigned CNT_W = cnt_w(WORD_W);

   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ*WORD_W-1:0] req_data;
   logic [N_REQ-1:0]        req_ready;
   logic                    resp_valid;
   logic [ID_W-1:0]         resp_id;
   logic [CNT_W-1:0]        resp_count;
   logic                    resp_ready;
   logic                    busy;

   modport master (
      output req_valid, req_data, resp_ready,
      input  req_ready, resp_valid, resp_id, resp_count, busy
   );

   modport slave (
      input  req_valid, req_data, resp_ready,
      output req_ready, resp_valid, resp_id, resp_count, busy
   );

endinterface

// File: rtl/serial_pattern_window.sv
// serial_pattern_window: PAT_LEN-bit shift window with pattern compare.
//   clk, rst (async, active-low), clear (sync window clear), bit_in, bit_en
//   match : combinational, window contents after this cycle's shift == PATTERN
// The oldest bit sits in the window MSB and is compared with PATTERN MSB.
module serial_pattern_window #(
   parameter int unsigned          PAT_LEN = 6,
   parameter logic [PAT_LEN-1:0]   PATTERN = 6'b110011
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic bit_in,
   input  logic bit_en,
   output logic match
);

   logic [PAT_LEN-1:0] window;
   logic [PAT_LEN-1:0] window_next;

   // Shift the new bit in at the LSB end.
   generate
      if (PAT_LEN == 1) begin : g_single
         always_comb window_next = bit_en ? bit_in : window;
      end else begin : g_multi
         always_comb window_next = bit_en ? {window[PAT_LEN-2:0], bit_in} : window;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)       window <= '0;
      else if (clear) window <= '0;
      else            window <= window_next;
   end

   assign match = (window_next == PATTERN);

endmodule

// File: rtl/pattern_scan_scheduler.sv
// pattern_scan_scheduler: round-robin shares one serial pattern detector
// among N_REQ requesters; each word is scanned MSB-first, one bit per clock,
// and the overlapping match count is returned tagged with the requester id.
//   clk, rst (async, active-low)
//   bus (slave modport of pattern_scan_scheduler_if): request and response
//   channels plus busy. req_ready is combinational (IDLE only); all other
//   outputs are registered.
// Build option: PSS_EARLY_EXIT_EN ends the scan at the first counted match.
module pattern_scan_scheduler
   import pss_pkg::*;
#(
   parameter int unsigned        N_REQ   = 4,
   parameter int unsigned        WORD_W  = 16,
   parameter int unsigned        PAT_LEN = 6,
   parameter logic [PAT_LEN-1:0] PATTERN = 6'b110011
) (
   input logic                     clk,
   input logic                     rst,
   pattern_scan_scheduler_if.slave bus
);

   localparam int unsigned ID_W  = $clog2(N_REQ);
   localparam int unsigned CNT_W = cnt_w(WORD_W);

   pss_state_t        state, state_next;
   logic [ID_W-1:0]   rr_ptr, rr_ptr_next;
   logic [WORD_W-1:0] word, word_next;
   logic [CNT_W-1:0]  bit_cnt, bit_cnt_next;
   logic [CNT_W-1:0]  count, count_next;
   logic [ID_W-1:0]   resp_id_q, resp_id_next;
   logic              resp_valid_q, resp_valid_next;
   logic              busy_q, busy_next;

   logic              any_valid;
   logic              take;
   logic [ID_W-1:0]   grant_idx;
   logic [N_REQ-1:0]  grant_oh;
   logic              win_clear;
   logic              win_en;
   logic              match;
   logic [WORD_W-1:0] req_word [N_REQ];

   // Unpack the flat request bus into per-requester words.
   for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
      assign req_word[i] = bus.req_data[i*WORD_W +: WORD_W];
   end

   // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
   always_comb begin
      int unsigned idx;
      idx       = 0;
      any_valid = 1'b0;
      grant_idx = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         idx = (32'(rr_ptr) + k) % N_REQ;
         if (!any_valid && bus.req_valid[ID_W'(idx)]) begin
            any_valid = 1'b1;
            grant_idx = ID_W'(idx);
         end
      end
   end

   // Gated by rst so no grant is shown while reset is asserted.
   assign take = (state == IDLE) && any_valid && rst;

   always_comb begin
      grant_oh = '0;
      if (take) grant_oh[grant_idx] = 1'b1;
   end

   serial_pattern_window #(
      .PAT_LEN (PAT_LEN),
      .PATTERN (PATTERN)
   ) u_window (
      .clk    (clk),
      .rst    (rst),
      .clear  (win_clear),
      .bit_in (word[WORD_W-1]),
      .bit_en (win_en),
      .match  (match)
   );

   // Next-state and datapath control.
   always_comb begin
      state_next      = state;
      rr_ptr_next     = rr_ptr;
      word_next       = word;
      bit_cnt_next    = bit_cnt;
      count_next      = count;
      resp_id_next    = resp_id_q;
      resp_valid_next = resp_valid_q;
      busy_next       = busy_q;
      win_clear       = 1'b0;
      win_en          = 1'b0;

      unique case (state)
         IDLE: begin
            if (take) begin
               word_next    = req_word[grant_idx];
               resp_id_next = grant_idx;
               rr_ptr_next  = ID_W'(rr_next(32'(grant_idx), N_REQ));
               bit_cnt_next = '0;
               count_next   = '0;
               win_clear    = 1'b1;
               busy_next    = 1'b1;
               state_next   = SHIFT;
            end
         end
         SHIFT: begin
            win_en       = 1'b1;
            word_next    = word << 1;
            bit_cnt_next = bit_cnt + 1'b1;
            // Only a fully populated window may count.
            if (bit_cnt_next >= CNT_W'(PAT_LEN) && match) begin
               count_next = count + 1'b1;
`ifdef PSS_EARLY_EXIT_EN
               state_next      = REPORT;
               resp_valid_next = 1'b1;
`endif
            end
            if (bit_cnt_next == CNT_W'(WORD_W)) begin
               state_next      = REPORT;
               resp_valid_next = 1'b1;
            end
         end
         REPORT: begin
            if (bus.resp_ready) begin
               resp_valid_next = 1'b0;
               busy_next       = 1'b0;
               state_next      = IDLE;
            end
         end
         default: begin
            resp_valid_next = 1'b0;
            busy_next       = 1'b0;
            state_next      = IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         rr_ptr       <= '0;
         word         <= '0;
         bit_cnt      <= '0;
         count        <= '0;
         resp_id_q    <= '0;
         resp_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state        <= state_next;
         rr_ptr       <= rr_ptr_next;
         word         <= word_next;
         bit_cnt      <= bit_cnt_next;
         count        <= count_next;
         resp_id_q    <= resp_id_next;
         resp_valid_q <= resp_valid_next;
         busy_q       <= busy_next;
      end
   end

   assign bus.req_ready  = grant_oh;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_id    = resp_id_q;
   assign bus.resp_count = count;
   assign bus.busy       = busy_q;

endmodule

// File: tb/tb_pattern_scan_scheduler.sv
// tb_pattern_scan_scheduler: directed self-checking bench for
// pattern_scan_scheduler (N_REQ=4, WORD_W=16, PAT_LEN=6, PATTERN=110011).
// Expectations adapt when PSS_EARLY_EXIT_EN is defined.
module tb_pattern_scan_scheduler;

   localparam int unsigned N_REQ  = 4;
   localparam int unsigned WORD_W = 16;
`ifdef PSS_EARLY_EXIT_EN
   localparam int CCC0_CNT = 1;
   localparam int CCC0_LAT = 7;
`else
   localparam int CCC0_CNT = 2;
   localparam int CCC0_LAT = 17;
`endif
   localparam int FULL_LAT = 17;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  tb_valid;
   logic [15:0] tb_word [4];
   int          n_assert = 0;
   int          n_fail   = 0;

   logic [15:0] w4 [4];
   int          c4 [4];
   int          l4 [4];

   always #5 clk = ~clk;

   pattern_scan_scheduler_if #(.N_REQ(N_REQ), .WORD_W(WORD_W)) bus ();

   always_comb begin
      bus.req_valid = tb_valid;
      bus.req_data  = {tb_word[3], tb_word[2], tb_word[1], tb_word[0]};
   end

   pattern_scan_scheduler #(
      .N_REQ   (N_REQ),
      .WORD_W  (WORD_W),
      .PAT_LEN (6),
      .PATTERN (6'b110011)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for a grant, check it, then pass the handshake edge.
   task automatic wait_grant(input logic [1:0] exp_g, input string tag);
      int n = 0;
      #1;
      while (bus.req_ready == 4'b0 && n < 40) begin
         tick();
         n++;
      end
      chk({tag, " grant"}, 32'(bus.req_ready), 32'(4'b0001 << exp_g));
      tick();
      chk({tag, " shift busy"}, 32'(bus.busy), 32'd1);
   endtask

   // Called in the first SHIFT cycle; n counts cycles since the handshake.
   task automatic wait_resp(input logic [1:0] exp_id, input int exp_cnt,
                            input int exp_lat, input string tag);
      int n = 1;
      while (!bus.resp_valid && n < 40) begin
         chk({tag, " no ready"}, 32'(bus.req_ready), 32'd0);
         tick();
         n++;
      end
      chk({tag, " latency"}, 32'(n), 32'(exp_lat));
      chk({tag, " id"}, 32'(bus.resp_id), 32'(exp_id));
      chk({tag, " count"}, 32'(bus.resp_count), 32'(exp_cnt));
      chk({tag, " busy"}, 32'(bus.busy), 32'd1);
   endtask

   task automatic accept(input string tag);
      bus.resp_ready = 1'b1;
      tick();
      chk({tag, " idle valid"}, 32'(bus.resp_valid), 32'd0);
      chk({tag, " idle busy"}, 32'(bus.busy), 32'd0);
   endtask

   task automatic run_word(input logic [1:0] i, input logic [15:0] w,
                           input int exp_cnt, input int exp_lat, input string tag);
      tb_word[i]  = w;
      tb_valid[i] = 1'b1;
      wait_grant(i, tag);
      tb_valid[i] = 1'b0;
      wait_resp(i, exp_cnt, exp_lat, tag);
      accept(tag);
   endtask

   initial begin
      rst            = 1'b0;
      tb_valid       = 4'b0;
      for (int i = 0; i < 4; i++) tb_word[i] = 16'h0;
      bus.resp_ready = 1'b1;
      w4 = '{16'hCCC0, 16'h0033, 16'h0000, 16'h0033};
      c4 = '{CCC0_CNT, 1, 0, 1};
      l4 = '{CCC0_LAT, FULL_LAT, FULL_LAT, FULL_LAT};

      // Reset values
      repeat (2) tick();
      chk("rst req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst resp_id", 32'(bus.resp_id), 32'd0);
      chk("rst resp_count", 32'(bus.resp_count), 32'd0);
      chk("rst busy", 32'(bus.busy), 32'd0);
      rst = 1'b1;
      tick();

      // Basic word with two overlapping matches
      run_word(2'd0, 16'hCCC0, CCC0_CNT, CCC0_LAT, "t1 ccc0");

      // Back-to-back words, edge cases, no cross-word match
      run_word(2'd0, 16'h0033, 1, FULL_LAT, "t2 0033");
      run_word(2'd0, 16'h0000, 0, FULL_LAT, "t2 0000");
      run_word(2'd0, 16'hFFFF, 0, FULL_LAT, "t2 ffff");
      run_word(2'd1, 16'h000C, 0, FULL_LAT, "t2 000c");
      run_word(2'd1, 16'hC000, 0, FULL_LAT, "t2 c000");

      // All requesters pending from reset: grants 0,1,2,3,0
      rst = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) tb_word[i] = w4[i];
      tb_valid = 4'hF;
      #1;
      chk("t3 rst gate", 32'(bus.req_ready), 32'd0);
      tick();
      rst = 1'b1;
      for (int k = 0; k < 5; k++) begin
         wait_grant(2'(k % 4), "t3 rr");
         if (k == 4) tb_valid = 4'b0;
         wait_resp(2'(k % 4), c4[k % 4], l4[k % 4], "t3 rr");
         accept("t3 rr");
      end

      // Backpressure in REPORT with another request pending
      bus.resp_ready = 1'b0;
      tb_word[0]     = 16'h0033;
      tb_valid[0]    = 1'b1;
      wait_grant(2'd0, "t4 bp");
      tb_valid[0]    = 1'b0;
      tb_word[2]     = 16'hCCC0;
      tb_valid[2]    = 1'b1;
      wait_resp(2'd0, 1, FULL_LAT, "t4 bp");
      repeat (5) begin
         tick();
         chk("t4 hold valid", 32'(bus.resp_valid), 32'd1);
         chk("t4 hold id", 32'(bus.resp_id), 32'd0);
         chk("t4 hold count", 32'(bus.resp_count), 32'd1);
         chk("t4 hold ready", 32'(bus.req_ready), 32'd0);
      end
      bus.resp_ready = 1'b1;
      #1;
      chk("t4 release valid", 32'(bus.resp_valid), 32'd1);
      tick();
      chk("t4 idle valid", 32'(bus.resp_valid), 32'd0);
      chk("t4 idle busy", 32'(bus.busy), 32'd0);
      chk("t4 idle grant", 32'(bus.req_ready), 32'h4);
      wait_grant(2'd2, "t4 next");
      tb_valid[2] = 1'b0;
      wait_resp(2'd2, CCC0_CNT, CCC0_LAT, "t4 next");
      accept("t4 next");

      // Reset during SHIFT cycle 7 aborts the word
      tb_word[2]  = 16'hCCC0;
      tb_valid[2] = 1'b1;
      wait_grant(2'd2, "t5 abort");
      tb_valid[2] = 1'b0;
      repeat (6) tick();
      rst = 1'b0;
      #1;
      chk("t5 rst req_ready", 32'(bus.req_ready), 32'd0);
      chk("t5 rst resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("t5 rst resp_id", 32'(bus.resp_id), 32'd0);
      chk("t5 rst resp_count", 32'(bus.resp_count), 32'd0);
      chk("t5 rst busy", 32'(bus.busy), 32'd0);
      tick();
      rst = 1'b1;
      repeat (20) begin
         tick();
         chk("t5 no resp", 32'(bus.resp_valid), 32'd0);
         chk("t5 idle busy", 32'(bus.busy), 32'd0);
      end
      tb_word[0] = 16'h0033;
      tb_word[3] = 16'h0033;
      tb_valid   = 4'b1001;
      wait_grant(2'd0, "t5 new");
      tb_valid   = 4'b0;
      wait_resp(2'd0, 1, FULL_LAT, "t5 new");
      accept("t5 new");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/pattern_scan_scheduler.md
# pattern_scan_scheduler

Shares one serial "110011"-style pattern detector among several requesters. Each requester submits a parallel word over a valid/ready handshake. A round-robin arbiter grants one requester at a time. The word is shifted MSB-first through the detector, one bit per clock, and the number of (overlapping) pattern matches is returned on a response channel tagged with the requester index. It sits between bus-side producers and the serial sequence-detection logic.

## Interface
- N_REQ, 4: number of requesters (2..8)
- WORD_W, 16: bits per submitted word (≥ PAT_LEN)
- PAT_LEN, 6: pattern length in bits (1..WORD_W)
- PATTERN, 6'b110011: pattern; its MSB is compared against the oldest bit
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  per-requester word valid
- req_data  in  N_REQ*WORD_W  requester i occupies bits [i*WORD_W +: WORD_W]
- req_ready  out  N_REQ  one-hot grant/accept; at most one bit set
- resp_valid  out  1  result available
- resp_id  out  $clog2(N_REQ)  requester index of the result
- resp_count  out  CNT_W = $clog2(WORD_W+1)  match count for the word
- resp_ready  in  1  consumer accepts the result
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, SHIFT, REPORT.
- IDLE:
  - When any req_valid is set, grant the first requester at or after rr_ptr, wrapping.
  - req_ready[g] is combinational in IDLE only, so the handshake completes in that cycle.
  - On the handshake: capture word, resp_id ← g, rr_ptr ← (g+1) mod N_REQ, clear window, bit counter and match count, then go to SHIFT.
- SHIFT:
  - Each cycle, shift the next bit (MSB first) into a PAT_LEN-bit window.
  - When bits_shifted ≥ PAT_LEN and window == PATTERN, count is incremented.
  - Overlapping matches count separately.
  - After the WORD_W-th bit, go to REPORT.
- REPORT:
  - resp_valid is high; resp_id and resp_count are held stable.
  - On resp_valid && resp_ready, go to IDLE.
- The detector is cleared at every word start. Matches never span two words.
- The count saturates at neither bound. The maximum possible value is WORD_W−PAT_LEN+1, which always fits in CNT_W.
- req_valid may drop without a handshake. No request is accepted outside IDLE.
- Async reset, mid-operation included:
  - state=IDLE, rr_ptr=0, req_ready=0, resp_valid=0, resp_id=0, resp_count=0, busy=0.
  - The in-flight word is discarded and no response is produced for it.

## Timing
- Handshake in cycle T. SHIFT occupies cycles T+1..T+WORD_W. resp_valid rises at T+WORD_W+1.
- With resp_ready held high, the response handshake occurs at T+WORD_W+1. IDLE is at T+WORD_W+2, and the next grant can happen then.
- Result: one word per WORD_W+2 cycles at best.
- resp_valid, once high, stays high until accepted. Backpressure has no upper bound.
- All outputs except req_ready are registered.

## Configuration
- PSS_EARLY_EXIT_EN:
  - Defined: SHIFT ends in the cycle the first match is counted. REPORT follows with resp_count=1, or resp_count=0 if the full word ran without a match. Latency varies from PAT_LEN+1 to WORD_W+1 cycles after the handshake.
  - Undefined: the full word is always scanned, and all matches are counted.

## Structure
- Package pss_pkg:
  - state enum pss_state_t {IDLE, SHIFT, REPORT} (logic[1:0])
  - function for the next round-robin index
  - the CNT_W width helper
- Sub-module serial_pattern_window:
  - Inputs: clk, rst, clear, bit_in, bit_en.
  - Output: match, combinational on the window after the shift.
  - Parameterised by PAT_LEN and PATTERN.
- The scheduler holds the arbiter, FSM, word shifter and counter.

## Test plan
- Defaults; req0 sends 16'hCCC0 → req_ready[0] high one cycle; resp_valid at handshake+17; resp_id=0, resp_count=2 (overlapping matches at bit offsets 0 and 4).
- Back-to-back: req0 sends 16'h0033 (resp_count=1, last bit completes the match), then req0 sends 16'h0000 and 16'hFFFF → resp_count=0 for both. Next: req1 sends 16'h000C, then req1 sends 16'hC000 → resp_count=0 for both (no cross-word match).
- All four req_valid held high from reset → grants in order 0,1,2,3,0; resp_id follows the same order; never two req_ready bits set.
- resp_ready low for 5 cycles in REPORT → resp_valid, resp_id and resp_count stable; no req_ready while req_valid is pending; release → handshake, then IDLE next cycle.
- rst low during SHIFT cycle 7 → all outputs 0 immediately; after release, a new word is granted to req0 and gives the correct count; no response for the aborted word.
- PSS_EARLY_EXIT_EN defined; 16'hCCC0 → resp_count=1, resp_valid at handshake+7.
